// File: rtl/prime_seq_checker_pkg.sv
// prime_seq_checker shared definitions
// state encoding, prime constants and successor helpers
package prime_seq_checker_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [3:0] P0 = 4'd2;
  localparam logic [3:0] P1 = 4'd3;
  localparam logic [3:0] P2 = 4'd5;
  localparam logic [3:0] P3 = 4'd7;
  localparam logic [3:0] P4 = 4'd11;

  function automatic logic [3:0] succ(
    input logic [3:0] v
  );
    case (v)
      P0:      succ = P1;
      P1:      succ = P2;
      P2:      succ = P3;
      P3:      succ = P4;
      P4:      succ = P0;
      default: succ = 4'd0;
    endcase
  endfunction

  function automatic logic in_set(
    input logic [3:0] v
  );
    in_set = (succ(v) != 4'd0);
  endfunction

endpackage

// File: rtl/prime_seq_checker_if.sv
// prime_seq_checker stream and status bundle
// master drives samples, slave is the checker
interface prime_seq_checker_if #(
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic [3:0]       in_data;
  logic             locked;
  logic             err;
  logic             period_done;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       exp_data;

  modport master (
    output in_valid,
    output in_data,
    input  locked,
    input  err,
    input  period_done,
    input  err_cnt,
    input  exp_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output locked,
    output err,
    output period_done,
    output err_cnt,
    output exp_data
  );

endinterface

// File: rtl/prime_seq_checker_succ_lut.sv
// prime_succ_lut: sample -> {in_set, successor}
// purely combinational, built on the shared helpers
module prime_succ_lut
  import prime_seq_checker_pkg::*;
(
  input  logic [3:0] i_val,
  output logic       o_in_set,
  output logic [3:0] o_succ
);

  assign o_in_set = in_set(i_val);
  assign o_succ   = succ(i_val);

endmodule

// File: rtl/prime_seq_checker.sv
// prime_seq_checker: phase acquisition, lock and
// mismatch monitoring of the prime sequence stream
module prime_seq_checker
  import prime_seq_checker_pkg::*;
#(
  parameter int LOCK_N = 5,
  parameter int LOSS_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  prime_seq_checker_if.slave  bus
);

  localparam logic [3:0] LK = 4'(LOCK_N);
  localparam logic [3:0] LS = 4'(LOSS_N);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t           r_state;
  state_t           w_state_nx;
  logic [3:0]       r_run;
  logic [3:0]       w_run_nx;
  logic [3:0]       r_miss;
  logic [3:0]       w_miss_nx;
  logic [3:0]       r_exp;
  logic [3:0]       w_exp_nx;
  logic             r_err;
  logic             w_err_nx;
  logic             r_pd;
  logic             w_pd_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;

  logic             w_smp_in;
  logic [3:0]       w_smp_succ;
  logic [3:0]       w_exp_succ;
  logic             w_match;
  logic [3:0]       w_run_inc;
  logic [3:0]       w_miss_inc;

  prime_succ_lut u_lut (
    .i_val    (bus.in_data),
    .o_in_set (w_smp_in),
    .o_succ   (w_smp_succ)
  );

  assign w_exp_succ = succ(r_exp);
  assign w_match    = (bus.in_data == r_exp);
  assign w_run_inc  = r_run + 4'd1;
  assign w_miss_inc = r_miss + 4'd1;

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= HUNT;
      r_run   <= '0;
      r_miss  <= '0;
      r_exp   <= '0;
      r_err   <= 1'b0;
      r_pd    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_run   <= w_run_nx;
      r_miss  <= w_miss_nx;
      r_exp   <= w_exp_nx;
      r_err   <= w_err_nx;
      r_pd    <= w_pd_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // next state; idle cycles hold everything but pulses
  always_comb begin
    w_state_nx = r_state;
    w_run_nx   = r_run;
    w_miss_nx  = r_miss;
    w_exp_nx   = r_exp;
    w_err_nx   = 1'b0;
    w_pd_nx    = 1'b0;
    w_cnt_nx   = r_cnt;
    if (bus.in_valid) begin
      unique case (r_state)
        HUNT: begin
          if (w_smp_in) begin
            w_exp_nx   = w_smp_succ;
            w_run_nx   = 4'd1;
            w_state_nx = SYNC;
          end else begin
            w_exp_nx   = 4'd0;
          end
        end
        SYNC: begin
          if (w_match) begin
            w_run_nx = w_run_inc;
            w_exp_nx = w_smp_succ;
            if (w_run_inc == LK) begin
              w_state_nx = LOCK;
              w_miss_nx  = 4'd0;
            end
          end else if (w_smp_in) begin
            w_exp_nx = w_smp_succ;
            w_run_nx = 4'd1;
          end else begin
            w_state_nx = HUNT;
            w_exp_nx   = 4'd0;
            w_run_nx   = 4'd0;
          end
        end
        LOCK: begin
          w_exp_nx = w_exp_succ;
          if (w_match) begin
            w_miss_nx = 4'd0;
            w_pd_nx   = (bus.in_data == P4);
          end else begin
            w_err_nx  = 1'b1;
            w_miss_nx = w_miss_inc;
            if (r_cnt != CMAX) begin
              w_cnt_nx = r_cnt + 1'b1;
            end
            if (w_miss_inc == LS) begin
              w_state_nx = HUNT;
              w_exp_nx   = 4'd0;
              w_run_nx   = 4'd0;
            end
          end
        end
        default: begin
          w_state_nx = HUNT;
          w_exp_nx   = 4'd0;
          w_run_nx   = 4'd0;
          w_miss_nx  = 4'd0;
        end
      endcase
    end
  end

  assign bus.locked      = (r_state == LOCK);
  assign bus.err         = r_err;
  assign bus.period_done = r_pd;
  assign bus.err_cnt     = r_cnt;
  assign bus.exp_data    = r_exp;

endmodule

// File: tb/tb_prime_seq_checker.sv
// tb_prime_seq_checker: randomized stream against
// a sequence-level reference model plus literal pins
module tb_prime_seq_checker;

  localparam int LOCK_N = 5;
  localparam int LOSS_N = 2;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  prime_seq_checker_if #(.CNT_W(CNT_W)) bus();

  prime_seq_checker #(
    .LOCK_N (LOCK_N),
    .LOSS_N (LOSS_N),
    .CNT_W  (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  int primes [5] = '{2, 3, 5, 7, 11};

  // model: mode 0 = searching, 1 = gathering run, 2 = locked
  int m_mode;
  int m_exp;
  int m_run;
  int m_miss;
  int m_cnt;
  int m_err;
  int m_pd;
  int s_v;
  int s_d;

  function automatic int pidx(input int d);
    for (int i = 0; i < 5; i++)
      if (primes[i] == d) return i;
    return -1;
  endfunction

  function automatic int nextp(input int d);
    int i;
    i = pidx(d);
    if (i < 0) return 0;
    return primes[(i + 1) % 5];
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_run = 0; m_miss = 0;
    m_cnt = 0; m_err = 0; m_pd = 0;
  endtask

  task automatic model_step(input int v, input int d);
    m_err = 0;
    m_pd  = 0;
    if (v == 0) return;
    if (m_mode == 0) begin
      if (pidx(d) >= 0) begin
        m_mode = 1; m_run = 1; m_exp = nextp(d);
      end else m_exp = 0;
    end else if (m_mode == 1) begin
      if (d == m_exp) begin
        m_run++;
        m_exp = nextp(d);
        if (m_run >= LOCK_N) begin m_mode = 2; m_miss = 0; end
      end else if (pidx(d) >= 0) begin
        m_run = 1; m_exp = nextp(d);
      end else begin
        m_mode = 0; m_exp = 0; m_run = 0;
      end
    end else begin
      if (d == m_exp) begin
        m_miss = 0;
        if (d == 11) m_pd = 1;
        m_exp = nextp(m_exp);
      end else begin
        m_err = 1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        m_miss++;
        m_exp = nextp(m_exp);
        if (m_miss >= LOSS_N) begin
          m_mode = 0; m_exp = 0; m_run = 0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    s_v = int'(bus.in_valid);
    s_d = int'(bus.in_data);
    if (!rst) model_reset();
    else model_step(s_v, s_d);
    #1;
    if (chk_en) begin
      check("locked", int'(bus.locked), int'(m_mode == 2));
      check("err", int'(bus.err), m_err);
      check("period_done", int'(bus.period_done), m_pd);
      check("err_cnt", int'(bus.err_cnt), m_cnt);
      check("exp_data", int'(bus.exp_data), m_exp);
    end
  end

  task automatic send(input int d);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'(d);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 4'($urandom_range(0, 15));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_seq(input int a, input int b, input int c,
                          input int d, input int e);
    send(a); send(b); send(c); send(d); send(e);
  endtask

  int ph;
  int r;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 4'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_pd", int'(bus.period_done), 0);
    check("rst_cnt", int'(bus.err_cnt), 0);
    check("rst_exp", int'(bus.exp_data), 0);
    rst = 1'b1;
    chk_en = 1;

    send_seq(2, 3, 5, 7, 11);
    idle();
    check("t1_locked", int'(bus.locked), 1);
    check("t1_exp", int'(bus.exp_data), 2);
    check("t1_cnt", int'(bus.err_cnt), 0);
    check("t1_model_mode", m_mode, 2);
    send_seq(2, 3, 5, 7, 11);
    idle();
    check("t1_pd", int'(bus.period_done), 1);

    send(2); send(3); send(4);
    idle();
    check("t3_err", int'(bus.err), 1);
    check("t3_cnt", int'(bus.err_cnt), 1);
    check("t3_locked", int'(bus.locked), 1);
    check("t3_exp", int'(bus.exp_data), 7);
    send(7);
    idle();
    check("t3_err7", int'(bus.err), 0);
    check("t3_exp11", int'(bus.exp_data), 11);

    send_seq(11, 2, 3, 9, 9);
    idle();
    check("t4_err", int'(bus.err), 1);
    check("t4_cnt", int'(bus.err_cnt), 3);
    check("t4_locked", int'(bus.locked), 0);
    check("t4_exp", int'(bus.exp_data), 0);
    send_seq(2, 3, 5, 7, 11);
    idle();
    check("t4_relock", int'(bus.locked), 1);
    check("t4_cnt_keep", int'(bus.err_cnt), 3);
    check("t4_model_cnt", m_cnt, 3);

    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_locked", int'(bus.locked), 0);
    check("arst_cnt", int'(bus.err_cnt), 0);
    check("arst_exp", int'(bus.exp_data), 0);
    check("arst_err", int'(bus.err), 0);
    check("arst_pd", int'(bus.period_done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    send(2); send(3); send(9);
    idle();
    check("t5_hunt_exp", int'(bus.exp_data), 0);
    send_seq(5, 7, 2, 3, 7);
    idle();
    check("t5_exp", int'(bus.exp_data), 11);
    check("t5_locked", int'(bus.locked), 0);
    check("t5_cnt", int'(bus.err_cnt), 0);
    check("t5_model_run", m_run, 1);

    do_reset();
    send(7);  repeat ($urandom_range(1, 3)) idle();
    send(11); repeat ($urandom_range(1, 3)) idle();
    send(2);  repeat ($urandom_range(1, 3)) idle();
    send(3);  repeat ($urandom_range(1, 3)) idle();
    check("t6_prelock", int'(bus.locked), 0);
    send(5);
    idle();
    check("t6_locked", int'(bus.locked), 1);
    check("t6_exp", int'(bus.exp_data), 7);

    ph = $urandom_range(0, 4);
    repeat (3000) begin
      if ($urandom_range(0, 4) == 0) idle();
      r = $urandom_range(0, 99);
      if (r < 6) send($urandom_range(0, 15));
      else send(primes[ph]);
      if (r == 6 || r == 7) ph = $urandom_range(0, 4);
      else ph = (ph + 1) % 5;
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
